// File: rtl/switch_event_controller.sv
// ============================================================================
// switch_event_controller
//
// Purpose:
//   Slide-switch peripheral sequencer. The 16 raw switch pins are brought into
//   the CLK domain through a two-flop synchroniser. One shared counter then
//   debounces them: a new value is committed only after it has been stable for
//   DebounceCycles cycles. Each committed change is accumulated into a sticky
//   change mask and can raise a CPU interrupt through a raise/ack handshake.
//   The stable value, the change mask and a control register are visible on a
//   shared 8-bit bus at BaseAddr..BaseAddr+4.
//
// Register map (offset from BaseAddr):
//   0 STAT_L  stable[7:0]   RO
//   1 STAT_H  stable[15:8]  RO
//   2 MASK_L  mask[7:0]     RO
//   3 MASK_H  mask[15:8]    RO
//   4 CTRL    bit0 IRQ_EN (RW), bit1 CLR (write 1 clears mask, reads 0),
//             bit2 RISE_ONLY (RW, only with SWEVT_RISING_FILTER_EN)
//
// Optional feature macro:
//   SWEVT_RISING_FILTER_EN - when defined, CTRL bit2 selects rising-edge-only
//   change detection. When undefined, bit2 reads 0 and all edges count.
//
// Ports:
//   CLK                  in     system clock
//   RESET                in     synchronous active-high reset
//   SWITCHES_RAW[15:0]   in     asynchronous switch pins
//   BUS_DATA[7:0]        inout  shared data bus, driven only for our reads
//   BUS_ADDR[7:0]        in     bus address
//   BUS_WE               in     bus write enable (1 = CPU write)
//   BUS_INTERRUPT_RAISE  out    interrupt request to the CPU
//   BUS_INTERRUPT_ACK    in     one-cycle acknowledge from the CPU
//   SWITCHES_STABLE[15:0] out   debounced switch value
// ============================================================================
module switch_event_controller #(
    parameter logic [7:0] BaseAddr       = 8'hC4,
    parameter int         DebounceCycles = 50000,
    parameter int         CntWidth       = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] SWITCHES_RAW,
    inout  wire  [7:0]  BUS_DATA,
    input  logic [7:0]  BUS_ADDR,
    input  logic        BUS_WE,
    output logic        BUS_INTERRUPT_RAISE,
    input  logic        BUS_INTERRUPT_ACK,
    output logic [15:0] SWITCHES_STABLE
);

    localparam logic [CntWidth-1:0] CntLast = CntWidth'(DebounceCycles - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RAISE = 2'd1,
        ST_REARM = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    logic [15:0]         sync1_reg;
    logic [15:0]         sync2_reg;
    logic [15:0]         candidate_reg;
    logic [CntWidth-1:0] count_reg;
    logic [15:0]         stable_reg;
    logic [15:0]         mask_reg;
    logic                primed_reg;
    logic                irq_en_reg;
    logic                rise_only_reg;
    logic [7:0]          rd_data_reg;
    logic                rd_valid_reg;
    state_t              state_reg;
    state_t              state_next;
    logic                pending_reg;
    logic                pending_next;

    // ------------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------------
    logic [7:0] offset;
    logic       in_range;
    logic       ctrl_wr;
    logic       clr_pulse;
    logic [7:0] rd_mux;

    // Modular subtraction keeps the window correct for any BaseAddr.
    assign offset    = BUS_ADDR - BaseAddr;
    assign in_range  = (offset <= 8'd4);
    assign ctrl_wr   = BUS_WE && (offset == 8'd4);
    assign clr_pulse = ctrl_wr && BUS_DATA[1];

    // ------------------------------------------------------------------------
    // Commit detection and change term
    // ------------------------------------------------------------------------
    logic        commit;
    logic [15:0] term;
    logic        change_commit;

    assign commit = (count_reg == CntLast) && (candidate_reg != stable_reg);

`ifdef SWEVT_RISING_FILTER_EN
    assign term = rise_only_reg ? (candidate_reg & ~stable_reg)
                                : (candidate_reg ^ stable_reg);
    logic unused_bus_bits;
    assign unused_bus_bits = ^BUS_DATA[7:3];
`else
    assign term = candidate_reg ^ stable_reg;
    logic unused_bus_bits;
    assign unused_bus_bits = ^{BUS_DATA[7:2], rise_only_reg};
`endif

    // The first commit after reset only establishes the baseline value.
    assign change_commit = commit && primed_reg && (|term);

    // ------------------------------------------------------------------------
    // Synchroniser and debounce
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1_reg     <= '0;
            sync2_reg     <= '0;
            candidate_reg <= '0;
            count_reg     <= '0;
            stable_reg    <= '0;
        end else begin
            sync1_reg <= SWITCHES_RAW;
            sync2_reg <= sync1_reg;
            // Any bit moving restarts the shared count for all bits.
            if (sync2_reg != candidate_reg) begin
                candidate_reg <= sync2_reg;
                count_reg     <= '0;
            end else if (count_reg != CntLast) begin
                count_reg <= count_reg + 1'b1;
            end
            if (commit) begin
                stable_reg <= candidate_reg;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Change mask and priming
    // ------------------------------------------------------------------------
    logic [15:0] mask_base;
    assign mask_base = clr_pulse ? 16'h0000 : mask_reg;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            mask_reg   <= '0;
            primed_reg <= 1'b0;
        end else begin
            // A clear coinciding with a commit keeps the freshly changed bits.
            if (commit && primed_reg) begin
                mask_reg <= mask_base | term;
            end else begin
                mask_reg <= mask_base;
            end
            if (commit) begin
                primed_reg <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Control register
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            irq_en_reg    <= 1'b0;
            rise_only_reg <= 1'b0;
        end else if (ctrl_wr) begin
            irq_en_reg <= BUS_DATA[0];
`ifdef SWEVT_RISING_FILTER_EN
            rise_only_reg <= BUS_DATA[2];
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Registered read path: data is on the bus for the cycle after decode.
    // ------------------------------------------------------------------------
    always_comb begin
        rd_mux = 8'h00;
        case (offset[2:0])
            3'd0:    rd_mux = stable_reg[7:0];
            3'd1:    rd_mux = stable_reg[15:8];
            3'd2:    rd_mux = mask_reg[7:0];
            3'd3:    rd_mux = mask_reg[15:8];
            3'd4:    rd_mux = {5'b00000, rise_only_reg, 1'b0, irq_en_reg};
            default: rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= !BUS_WE && in_range;
            rd_data_reg  <= rd_mux;
        end
    end

    assign BUS_DATA = rd_valid_reg ? rd_data_reg : 8'hzz;

    // ------------------------------------------------------------------------
    // Interrupt handshake FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg   <= ST_IDLE;
            pending_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pending_next = pending_reg;
        case (state_reg)
            ST_IDLE: begin
                pending_next = 1'b0;
                if (change_commit && irq_en_reg) begin
                    state_next = ST_RAISE;
                end
            end
            ST_RAISE: begin
                if (!irq_en_reg) begin
                    state_next   = ST_IDLE;
                    pending_next = 1'b0;
                end else if (BUS_INTERRUPT_ACK) begin
                    // A commit landing on the ack cycle counts as pending.
                    state_next   = (pending_reg || change_commit) ? ST_REARM : ST_IDLE;
                    pending_next = 1'b0;
                end else if (change_commit) begin
                    pending_next = 1'b1;
                end
            end
            ST_REARM: begin
                if (!irq_en_reg) begin
                    state_next   = ST_IDLE;
                    pending_next = 1'b0;
                end else begin
                    // A commit during the low cycle must not be lost.
                    state_next   = ST_RAISE;
                    pending_next = change_commit;
                end
            end
            default: begin
                state_next   = ST_IDLE;
                pending_next = 1'b0;
            end
        endcase
    end

    always_comb begin
        BUS_INTERRUPT_RAISE = (state_reg == ST_RAISE);
    end

    assign SWITCHES_STABLE = stable_reg;

endmodule
